// File: rtl/router_1xn.sv
// router_1xn: 1-to-N byte-serial packet router with per-port FIFOs and read-timeout soft reset.
// Define ROUTER_LEN_CHECK_EN to also flag header-length mismatches on err.
module router_1xn #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             pkt_valid,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [NUM_PORTS-1:0]             read_enb,
  output logic [NUM_PORTS-1:0]             vld_out,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  data_out,
  output logic                             busy,
  output logic                             err,
  output logic                             drop
);
  localparam int LEN_WIDTH = DATA_WIDTH - ADDR_WIDTH;
  localparam int NA = 2 ** ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] NP = (ADDR_WIDTH + 1)'(NUM_PORTS);

  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD, CHECK, DROP} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] hdr_q, hdr_d, par_q, par_d, wdata;
  logic cmp_q, cmp_d, err_q, err_d, drop_q, drop_d, wr, len_bad;
  logic [NUM_PORTS-1:0] full, empty, flush;
  logic [NA-1:0] full_x, empty_x, flush_x;
  logic [ADDR_WIDTH-1:0] dest;

  // Unused address codes read as not-empty/not-full/no-flush
  assign full_x  = NA'(full);
  assign empty_x = NA'(empty);
  assign flush_x = NA'(flush);
  assign dest    = state_q == IDLE ? data_in[ADDR_WIDTH-1:0] : hdr_q[ADDR_WIDTH-1:0];
  assign wdata   = state_q == WAIT_EMPTY ? hdr_q : data_in;
  assign err     = err_q;
  assign drop    = drop_q;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    par_d   = par_q;
    cmp_d   = cmp_q;
    err_d   = err_q;
    drop_d  = 1'b0;
    wr      = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: if (pkt_valid) begin
        hdr_d   = data_in;
        par_d   = data_in;
        wr      = empty_x[dest];
        state_d = empty_x[dest] ? LOAD : {1'b0, dest} >= NP ? DROP : WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        busy    = 1'b1;
        wr      = empty_x[dest];
        state_d = empty_x[dest] ? LOAD : WAIT_EMPTY;
      end
      LOAD: begin
        busy = full_x[dest];
        // A timed-out destination abandons the rest of the packet
        if (flush_x[dest]) begin
          drop_d  = !busy && !pkt_valid;
          state_d = drop_d ? IDLE : DROP;
        end else if (!busy) begin
          wr      = 1'b1;
          par_d   = pkt_valid ? par_q ^ data_in : par_q;
          cmp_d   = par_q != data_in || len_bad;
          state_d = pkt_valid ? LOAD : CHECK;
        end
      end
      CHECK: begin
        busy    = 1'b1;
        err_d   = cmp_q;
        state_d = IDLE;
      end
      DROP: if (!pkt_valid) begin
        drop_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      par_q   <= '0;
      cmp_q   <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      par_q   <= par_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

`ifdef ROUTER_LEN_CHECK_EN
  logic [LEN_WIDTH:0] len_q, len_d;
  always_comb
    len_d = state_q == IDLE ? '0 :
            state_q == LOAD && !busy && pkt_valid && !flush_x[dest] && !(&len_q) ? len_q + (LEN_WIDTH + 1)'(1) : len_q;
  always_ff @(posedge clock) len_q <= !resetn ? '0 : len_d;
  assign len_bad = len_q != {1'b0, hdr_q[DATA_WIDTH-1:ADDR_WIDTH]};
`else
  assign len_bad = 1'b0;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic we, re;
    assign empty[p] = wp_q == rp_q;
    assign full[p]  = wp_q[PW] != rp_q[PW] && wp_q[PW-1:0] == rp_q[PW-1:0];
    assign vld_out[p] = !empty[p];
    assign flush[p] = vld_out[p] && !read_enb[p] && cnt_q == CW'(TIMEOUT - 1);
    assign we = wr && dest == ADDR_WIDTH'(p);
    assign re = read_enb[p] && !empty[p];
    assign data_out[p*DATA_WIDTH +: DATA_WIDTH] = dout_q;
    always_comb begin
      wp_d   = flush[p] ? '0 : wp_q + (PW + 1)'(we);
      rp_d   = flush[p] ? '0 : rp_q + (PW + 1)'(re);
      cnt_d  = empty[p] || read_enb[p] || flush[p] ? '0 : cnt_q + CW'(1);
      dout_d = re ? mem[rp_q[PW-1:0]] : dout_q;
    end
    always_ff @(posedge clock) begin
      if (!resetn) begin
        wp_q   <= '0;
        rp_q   <= '0;
        cnt_q  <= '0;
        dout_q <= '0;
      end else begin
        wp_q   <= wp_d;
        rp_q   <= rp_d;
        cnt_q  <= cnt_d;
        dout_q <= dout_d;
      end
    end
    always_ff @(posedge clock)
      if (we) mem[wp_q[PW-1:0]] <= wdata;
  end
endmodule

// File: doc/router_1xn.md
# router_1xn

Parametrised 1-to-N packet router: one byte-serial input stream is demultiplexed by header address into NUM_PORTS independent output FIFOs. It carries the existing FSM, register, synchroniser and FIFO functions in one block, and generalises them in data width, port count, FIFO depth and soft-reset timeout. New over the 1x3 router: invalid-address packets are dropped with a `drop` pulse instead of stalling, and a length check is optional.

## Interface
- DATA_WIDTH, 8, byte width of data_in, data_out and FIFO entries.
- ADDR_WIDTH, 2, header address field, header[ADDR_WIDTH-1:0]; LEN_WIDTH = DATA_WIDTH-ADDR_WIDTH is header[DATA_WIDTH-1:ADDR_WIDTH].
- NUM_PORTS, 3, output ports, 2..2**ADDR_WIDTH.
- FIFO_DEPTH, 16, entries per port FIFO; power of 2, ≥4.
- TIMEOUT, 30, cycles a port may sit valid-but-unread before soft reset.
- clock  in  1  single clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- pkt_valid  in  1  high for header and payload bytes; low on the parity byte.
- data_in  in  DATA_WIDTH  input byte.
- read_enb  in  NUM_PORTS  per-port read request.
- vld_out  out  NUM_PORTS  per-port FIFO not empty.
- data_out  out  NUM_PORTS*DATA_WIDTH  per-port read data, port p at [p*DATA_WIDTH +: DATA_WIDTH].
- busy  out  1  input byte not accepted this cycle; source holds data_in and pkt_valid.
- err  out  1  last completed packet failed its check.
- drop  out  1  one-cycle pulse: packet discarded.

## Operation
- A byte is accepted at a rising edge when busy=0 and the FSM is in IDLE, LOAD or DROP.
- **IDLE** (busy=0): on pkt_valid=1, latch the header, set parity_acc=header and clear len_cnt.
  - addr ≥ NUM_PORTS → DROP.
  - destination empty → write header to FIFO on the same edge → LOAD.
  - otherwise → WAIT_EMPTY.
- **WAIT_EMPTY** (busy=1): when the destination is empty, write the latched header → LOAD.
- **LOAD** (busy = destination full):
  - pkt_valid=1: write payload, parity_acc ^= byte, len_cnt++ (saturating, LEN_WIDTH+1 bits).
  - pkt_valid=0: byte is parity. Write it to the FIFO, register the compare → CHECK.
- **CHECK** (busy=1, one cycle): err <= (parity_acc != received parity) [| length mismatch, see Configuration] → IDLE.
- **DROP** (busy=0): discard bytes while pkt_valid=1. The first pkt_valid=0 byte is consumed as parity. Assert drop for one cycle → IDLE. No FIFO write; err unchanged.
- **FIFO per port:**
  - vld_out = !empty, from registered pointers.
  - read_enb & !empty → data_out <= mem[rd_ptr], rd_ptr++.
  - data_out holds when not reading.
  - Pointers wrap at FIFO_DEPTH; one extra pointer bit distinguishes full from empty.
- **Soft reset per port:**
  - Counter increments while vld_out=1 and read_enb=0. It clears on read_enb=1 or empty.
  - On reaching TIMEOUT-1: flush the FIFO (pointers to 0, data_out unchanged) and clear the counter.
  - Flush of the destination while in LOAD → DROP for the remainder of the packet, drop pulses at its end.
  - Flush while in WAIT_EMPTY → destination becomes empty → normal header write.

## Timing
- **Reset** (resetn=0 at an edge): FSM IDLE, busy=0, err=0, drop=0, all vld_out=0, all data_out=0, pointers and counters 0.
- Header accepted into an empty destination at edge k → vld_out[p]=1 after edge k.
- read_enb sampled at edge k → new data_out valid after edge k.
- Full flag is registered. A read and a blocked write in the same cycle leave busy=1 that cycle; the write proceeds next cycle.
- Read on empty: ignored. A write and a read at the same edge on an empty FIFO: only the write takes effect.
- Flush and write on the same port at the same edge: flush wins, write discarded.
- err is updated only on the CHECK edge and holds until the next CHECK or reset.
- Minimum packet (header, 0 payload, parity) occupies IDLE→LOAD→CHECK, i.e. 3 cycles.

## Configuration
- ROUTER_LEN_CHECK_EN defined: CHECK also sets err when len_cnt != header length field.
- ROUTER_LEN_CHECK_EN undefined: err reflects parity only; len_cnt logic is not built.

## Test plan
- Port 0, len 14, payload 0..13, correct parity, read_enb[0] held after vld_out → 16 bytes out in order, err=0, busy never high in LOAD.
- Port 1, len 20, FIFO_DEPTH 16, no reads until busy=1 → busy rises on the 17th write; raising read_enb[1] releases it; all 22 bytes delivered, err=0.
- Port 2, parity byte corrupted (XOR 0x01) → err=1 after CHECK; the next good packet clears err to 0.
- Header addr=3 with NUM_PORTS=3, len 5 → drop pulses once after the parity byte; no vld_out rises; err unchanged.
- Port 0 loaded, read_enb[0]=0 for 30 cycles → vld_out[0] falls after the 30th cycle; a following header to port 0 is accepted with no WAIT_EMPTY.
- With ROUTER_LEN_CHECK_EN: header len 4, 5 payload bytes, parity correct over all bytes → err=1; without the macro → err=0.
